// File: rtl/vga_capture.sv
// Samples a VGA pixel stream on CLOCK_50 and turns it into framebuffer write
// pulses, checking line/frame geometry and tracking capture lock.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        VGA_CLK,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  input  logic        VGA_SYNC_N,
  output logic        wr_en,
  output logic [9:0]  wr_x,
  output logic [9:0]  wr_y,
  output logic [23:0] wr_rgb,
  output logic        frame_done,
  output logic        line_err,
  output logic        frame_err,
  output logic        locked
);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'h3ff;

  typedef enum logic [1:0] {SEARCH, SYNCED, LOCKED} state_t;

  typedef struct packed {
    logic        en;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } wr_t;

  logic        clk_s1_q, clk_s1_d, hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
  logic        blank_s1_q, blank_s1_d;
  logic [23:0] rgb_s1_q, rgb_s1_d;
  logic        clk_s2_q, clk_s2_d, hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [9:0]  x_q, x_d, y_q, y_d, good_q, good_d;
  logic        line_bad_q, line_bad_d;
  state_t      state_q, state_d;
  wr_t [1:0]   wr_pipe_q, wr_pipe_d;
  logic        frame_done_q, frame_done_d, line_err_q, line_err_d;
  logic        frame_err_q, frame_err_d;
  logic        strobe, hs_edge, vs_edge;
  logic        sync_unused;

  assign sync_unused = VGA_SYNC_N;

  assign strobe  = clk_s1_q & ~clk_s2_q;
  assign hs_edge = ~hs_s1_q & hs_prev_q;
  assign vs_edge = ~vs_s1_q & vs_prev_q;

  always_comb begin
    clk_s1_d     = VGA_CLK;
    hs_s1_d      = VGA_HS;
    vs_s1_d      = VGA_VS;
    blank_s1_d   = VGA_BLANK_N;
    rgb_s1_d     = {VGA_R, VGA_G, VGA_B};
    clk_s2_d     = clk_s1_q;
    hs_prev_d    = hs_s1_q;
    vs_prev_d    = vs_s1_q;
    x_d          = x_q;
    y_d          = y_q;
    good_d       = good_q;
    line_bad_d   = line_bad_q;
    state_d      = state_q;
    wr_pipe_d[0] = '0;
    wr_pipe_d[1] = wr_pipe_q[0];
    line_err_d   = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    // x counts every active strobe, even off-screen or while searching
    if (strobe && blank_s1_q) begin
      if (state_q != SEARCH && x_q < H_ACT && y_q < V_ACT)
        wr_pipe_d[0] = {1'b1, x_q, y_q, rgb_s1_q};
      if (x_q != CNT_MAX) x_d = x_q + 10'd1;
    end

    if (hs_edge) begin
      if (x_q != 10'd0) begin
        if (x_q != H_ACT) begin
          line_err_d = 1'b1;
          line_bad_d = 1'b1;
        end
        if (y_q != CNT_MAX) y_d = y_q + 10'd1;
      end
      x_d = 10'd0;
    end

    // VS judges the frame on y as already bumped by a coincident HS
    if (vs_edge) begin
      if (state_q != SEARCH) begin
        if (y_d != V_ACT || line_bad_d) frame_err_d  = 1'b1;
        else                            frame_done_d = 1'b1;
      end
      x_d        = 10'd0;
      y_d        = 10'd0;
      line_bad_d = 1'b0;
    end

    case (state_q)
      SEARCH: begin
        good_d = 10'd0;
        if (vs_edge) state_d = SYNCED;
      end
      SYNCED: begin
        if (frame_err_d) good_d = 10'd0;
        else if (frame_done_d) begin
          good_d = good_q + 10'd1;
          if (good_q >= 10'd1) begin
            state_d = LOCKED;
            good_d  = 10'd0;
          end
        end
      end
      LOCKED: begin
        if (line_err_d || frame_err_d) begin
          state_d = SYNCED;
          good_d  = 10'd0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      clk_s1_q     <= 1'b0;
      hs_s1_q      <= 1'b0;
      vs_s1_q      <= 1'b0;
      blank_s1_q   <= 1'b0;
      rgb_s1_q     <= '0;
      clk_s2_q     <= 1'b0;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      good_q       <= '0;
      line_bad_q   <= 1'b0;
      state_q      <= SEARCH;
      wr_pipe_q    <= '0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_s1_q     <= clk_s1_d;
      hs_s1_q      <= hs_s1_d;
      vs_s1_q      <= vs_s1_d;
      blank_s1_q   <= blank_s1_d;
      rgb_s1_q     <= rgb_s1_d;
      clk_s2_q     <= clk_s2_d;
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      x_q          <= x_d;
      y_q          <= y_d;
      good_q       <= good_d;
      line_bad_q   <= line_bad_d;
      state_q      <= state_d;
      wr_pipe_q    <= wr_pipe_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign wr_en      = wr_pipe_q[1].en;
  assign wr_x       = wr_pipe_q[1].x;
  assign wr_y       = wr_pipe_q[1].y;
  assign wr_rgb     = wr_pipe_q[1].rgb;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;
  assign locked     = (state_q == LOCKED);
endmodule
